bitstream_generator: RTL and testbench
======================================

BITSTREAM_GENERATOR -- requirements
Module: bitstream_generator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width and LFSR length; legal values 4, 8, 16 only, any other value SHALL fail elaboration.
REQ-002 Parameter: SEED, default 'hA5 (truncated to WIDTH), LFSR load value; SEED mod 2^WIDTH = 0 SHALL fail elaboration.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 value  input  WIDTH  unsigned operand to encode.
REQ-006 start  input  1  request to begin one stream; sampled in IDLE only.
REQ-007 x  output  1  serial bitstream to downstream integrator.
REQ-008 capture  output  1  window strobe to downstream integrator.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse marking stream completion.

Function
REQ-011 Define L = 2^WIDTH - 1 (stream length; 255 for WIDTH=8).
REQ-012 States SHALL be IDLE, RUN, TAIL, COOL; all outputs SHALL be driven directly from flops.
REQ-013 IDLE: start=1 -> latch value into val_q, load lfsr <= SEED, clear idx, next RUN; else stay IDLE.
REQ-014 RUN: capture=1 for exactly L cycles; idx counts 0..L-1; next TAIL when idx = L-1.
REQ-015 TAIL: one cycle; capture=0; next COOL.
REQ-016 COOL: one cycle; capture=0, done=1; next IDLE.
REQ-017 LFSR: Fibonacci, shifts once per RUN cycle; taps x^4+x^3+1 (W=4), x^8+x^6+x^5+x^4+1 (W=8), x^16+x^14+x^13+x^11+1 (W=16); LFSR never reaches zero.
REQ-018 Bit i (i=0..L-1) = (lfsr_i <= val_q), unsigned compare, where lfsr_i is the LFSR value in RUN cycle i.
REQ-019 x register loads bit i in RUN cycle i, so bit i appears on x one cycle later (RUN cycles 1..L-1 and TAIL); x SHALL be 0 in IDLE, COOL, and the first RUN cycle.
REQ-020 Alignment: the downstream integrator counts x from the cycle after capture rises through the first cycle capture is low; this SHALL yield exactly val_q ones in that window.
REQ-021 Because the LFSR visits each of 1..L once per stream, the total ones per stream SHALL equal val_q exactly (0..L).
REQ-022 value changes after the start cycle SHALL have no effect on the current stream.
REQ-023 start in RUN, TAIL or COOL SHALL be ignored, not queued.
REQ-024 Minimum capture-low gap between streams SHALL be 3 cycles (TAIL, COOL, IDLE).
REQ-025 Every stream SHALL restart the LFSR from SEED, so identical value gives an identical bit sequence.

Reset
REQ-026 n_rst=0 SHALL immediately force state=IDLE, x=0, capture=0, busy=0, done=0, idx=0, val_q=0, lfsr=SEED, regardless of state.
REQ-027 Reset deassertion mid-stream SHALL leave the block in IDLE awaiting start; no partial stream resumes.
REQ-028 start asserted coincident with reset release SHALL be ignored until the first clock edge with n_rst=1.

Verification
REQ-029 WIDTH=8, value=100, start pulsed in cycle 0 -> capture high cycles 1..255, x ones total = 100 over cycles 2..256, done=1 cycle 257, busy low cycle 258; integrator downstream outputs 100.
REQ-030 value=0 -> x=0 all stream cycles; value=255 -> x=1 cycles 2..256 (255 ones); done timing as REQ-029.
REQ-031 start held high continuously -> streams begin at cycles 0, 258, 516; start during RUN/TAIL/COOL ignored; capture low 3 cycles between streams.
REQ-032 value switched 100->7 at cycle 10 of RUN -> stream still contains exactly 100 ones.
REQ-033 n_rst pulsed low at RUN cycle 50 -> all outputs 0 same cycle, busy=0; subsequent start with value=100 produces bit sequence identical to REQ-029.
REQ-034 Sweep value 0..255 with back-to-back starts -> ones count equals value for every stream.

Source files
------------

// File: rtl/bitstream_generator.sv
// Stochastic bitstream encoder: emits a 2^WIDTH-1 cycle stream on x whose ones count equals the latched
// operand, by comparing the operand against a maximal-length LFSR that visits every nonzero value once.
module bitstream_generator #(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] SEED  = 32'hA5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] value,
    input  logic             start,
    output logic             x,
    output logic             capture,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] COOL = 2'd3;

    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
    // Index of the final RUN cycle, L-1 = 2^WIDTH - 2.
    localparam logic [WIDTH-1:0] IDX_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16)) begin : g_bad_width
        $error("bitstream_generator: WIDTH must be 4, 8 or 16");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("bitstream_generator: SEED truncated to WIDTH must be nonzero");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] val_q,   val_d;
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [WIDTH-1:0] idx_q,   idx_d;
    logic             x_d, capture_d, busy_d, done_d;
    logic             fb;

    // Fibonacci feedback taps for the supported lengths.
    if (WIDTH == 4) begin : g_fb4
        assign fb = lfsr_q[3] ^ lfsr_q[2];
    end else if (WIDTH == 8) begin : g_fb8
        assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end else begin : g_fb16
        assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            lfsr_q  <= SEED_W;
            idx_q   <= '0;
            x       <= 1'b0;
            capture <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            x       <= x_d;
            capture <= capture_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state plus next values of every registered output, decided from the upcoming state.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        lfsr_d    = lfsr_q;
        idx_d     = idx_q;
        x_d       = 1'b0;
        capture_d = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    val_d     = value;
                    lfsr_d    = SEED_W;
                    idx_d     = '0;
                    capture_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                x_d    = (lfsr_q <= val_q);
                lfsr_d = {lfsr_q[WIDTH-2:0], fb};
                if (idx_q == IDX_LAST) begin
                    state_d = TAIL;
                end else begin
                    idx_d     = idx_q + WIDTH'(1);
                    capture_d = 1'b1;
                end
            end
            TAIL: begin
                state_d = COOL;
                done_d  = 1'b1;
            end
            COOL: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bitstream_generator.sv
// Scoreboard bench for bitstream_generator (WIDTH=8): stimulus queues expected operands, a monitor
// checks every capture window against a reference LFSR/compare model plus the done/idle handshake.
module tb_bitstream_generator;

    localparam int L = 255;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] value = 8'd0;
    logic       start = 1'b0;
    logic       x, capture, busy, done;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    bit         held_phase = 1'b0;

    bitstream_generator #(.WIDTH(8), .SEED(32'hA5)) dut (
        .clk(clk), .n_rst(n_rst), .value(value), .start(start),
        .x(x), .capture(capture), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference LFSR: x^8+x^6+x^5+x^4+1, Fibonacci, shifting left.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Monitor
    bit         mon_prev_cap = 1'b0;
    bit         mon_in_win = 1'b0;
    int         mon_k, mon_ones, mon_mism, mon_done_age, mon_lowgap, mon_held_rises;
    logic [7:0] mon_lfsr, mon_val;

    initial begin
        mon_done_age = 0; mon_lowgap = 0; mon_held_rises = 0;
        mon_k = 0; mon_ones = 0; mon_mism = 0; mon_lfsr = 8'hA5; mon_val = 8'd0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                mon_prev_cap = 1'b0; mon_in_win = 1'b0; mon_done_age = 0; mon_lowgap = 0;
            end else begin
                if (mon_done_age == 1) begin
                    check(done === 1'b1 && x === 1'b0, "done_pulse", int'(done), 1);
                    mon_done_age = 2;
                end else if (mon_done_age == 2) begin
                    check(done === 1'b0 && busy === 1'b0, "idle_after_done", int'(busy), 0);
                    mon_done_age = 0;
                end else if (done === 1'b1) begin
                    check(1'b0, "spurious_done", 1, 0);
                end

                if (capture === 1'b1 && !mon_prev_cap) begin
                    if (held_phase) begin
                        if (mon_held_rises > 0) check(mon_lowgap == 3, "low_gap", mon_lowgap, 3);
                        mon_held_rises++;
                    end
                    mon_lowgap = 0;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_stream", 1, 0);
                        mon_in_win = 1'b0;
                    end else begin
                        mon_val    = exp_q.pop_front();
                        mon_in_win = 1'b1;
                        mon_k      = 0;
                        mon_ones   = 0;
                        mon_mism   = (x !== 1'b0) ? 1 : 0;
                        mon_lfsr   = 8'hA5;
                    end
                end else if (mon_in_win && (capture === 1'b1 || mon_prev_cap)) begin
                    if (x !== (mon_lfsr <= mon_val)) mon_mism++;
                    if (x === 1'b1) mon_ones++;
                    mon_k++;
                    mon_lfsr = lfsr_next(mon_lfsr);
                    if (capture !== 1'b1) begin
                        check(mon_k == L, "window_len", mon_k, L);
                        check(mon_ones == int'(mon_val), "ones_count", mon_ones, int'(mon_val));
                        check(mon_mism == 0, "bit_sequence", mon_mism, 0);
                        mon_in_win   = 1'b0;
                        mon_done_age = 1;
                    end
                end
                if (capture !== 1'b1) mon_lowgap++;
                mon_prev_cap = (capture === 1'b1);
            end
        end
    end

    // One stream: start pulsed in cycle 0, optional operand change at cycle chg.
    task automatic run_stream(input logic [7:0] v, input int chg, input logic [7:0] v2);
        int c;
        @(negedge clk);
        value = v;
        start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (done !== 1'b1 && c < 400) begin
            if (c == chg) value = v2;
            @(negedge clk);
            c++;
        end
        check(c == 257, "done_cycle", c, 257);
        @(negedge clk);
    endtask

    initial begin
        int c, nd;
        repeat (2) @(negedge clk);
        check(x === 1'b0, "reset_x", int'(x), 0);
        check(capture === 1'b0, "reset_capture", int'(capture), 0);
        check(busy === 1'b0, "reset_busy", int'(busy), 0);
        check(done === 1'b0, "reset_done", int'(done), 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_stream(8'd100, -1, 8'd0);
        run_stream(8'd0, -1, 8'd0);
        run_stream(8'd255, -1, 8'd0);
        run_stream(8'd100, 11, 8'd7);
        run_stream(8'd1, -1, 8'd0);

        // Start held high: streams every 258 cycles, start inside a stream ignored.
        @(negedge clk);
        held_phase = 1'b1;
        value = 8'd42;
        start = 1'b1;
        repeat (3) exp_q.push_back(8'd42);
        c = 0;
        nd = 0;
        while (nd < 3 && c < 1000) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) begin
                check(c == 257 + 258 * nd, "held_done_cycle", c, 257 + 258 * nd);
                nd++;
            end
        end
        start = 1'b0;
        check(nd == 3, "held_stream_count", nd, 3);
        repeat (3) @(negedge clk);
        held_phase = 1'b0;

        // Reset in RUN cycle 50, then a fresh stream must match the reference sequence.
        @(negedge clk);
        value = 8'd100;
        start = 1'b1;
        exp_q.push_back(8'd100);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        check(x === 1'b0, "abort_x", int'(x), 0);
        check(capture === 1'b0, "abort_capture", int'(capture), 0);
        check(busy === 1'b0, "abort_busy", int'(busy), 0);
        check(done === 1'b0, "abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check(busy === 1'b0 && capture === 1'b0, "abort_stays_idle", int'(busy), 0);
        run_stream(8'd100, -1, 8'd0);

        for (int v = 0; v < 256; v++) run_stream(8'(v), -1, 8'd0);

        repeat (4) @(negedge clk);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
